// File: rtl/dmadd_pkg.sv
// Shared opcode constants, FSM state encoding and operand beat layout
// for the delta-multiply-add sequencer.
package dmadd_pkg;

   localparam logic [1:0] OP_MIN     = 2'd0;
   localparam logic [1:0] OP_MAX     = 2'd1;
   localparam logic [1:0] OP_MADD    = 2'd2;
   localparam logic [1:0] OP_ILLEGAL = 2'd3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      INIT  = 3'd2,
      LOAD  = 3'd3,
      RUN   = 3'd4,
      DONE  = 3'd5
   } state_e;

   typedef struct packed {
      logic       last;
      logic [3:0] index;
      logic [3:0] data;
   } beat_t;

endpackage

// File: rtl/dmadd_opfifo.sv
// Synchronous operand FIFO; pointers carry one wrap bit so full and empty
// are distinguishable without a separate occupancy counter.
module dmadd_opfifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/dmadd_sequencer.sv
// Sequences one delta-multiply-add job per start request: engine clear, init,
// operand load from the FIFO, fixed-length run, then a held result handshake.
module dmadd_sequencer
   import dmadd_pkg::*;
#(
   parameter int RUN_CYCLES = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [3:0]  s_index,
   input  logic [3:0]  s_data,
   input  logic        s_last,
   output logic        dm_rst_n,
   output logic [1:0]  dm_insn,
   output logic [3:0]  dm_index,
   output logic [3:0]  dm_data,
   output logic        dm_load,
   output logic        dm_run,
   input  logic [11:0] dm_out,
   output logic        res_valid,
   output logic [11:0] res_data,
   input  logic        res_ready,
   output logic        busy,
   output logic        err
);

   logic [1:0]  rst_sync_q;
   logic        rst_int_n;
   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  insn_q, insn_d;
   logic [11:0] res_data_q, res_data_d;
   logic        err_q, err_d;
   beat_t       push_beat, head_beat;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;

   // Reset asserts immediately but releases two clock edges later, in step with clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   assign push_beat = '{last: s_last, index: s_index, data: s_data};
   assign s_ready   = rst_int_n && !fifo_full;
   assign fifo_push = s_valid && s_ready;

   dmadd_opfifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(beat_t))
   ) u_opfifo (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .push_i  (fifo_push),
      .wdata_i (push_beat),
      .pop_i   (fifo_pop),
      .rdata_o (head_beat),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      insn_d     = insn_q;
      res_data_d = res_data_q;
      err_d      = err_q;
      fifo_pop   = 1'b0;
      dm_load    = 1'b0;
      dm_index   = 4'd0;
      dm_data    = 4'd0;
      dm_run     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (op == OP_ILLEGAL) begin
                  err_d = 1'b1;
               end else begin
                  insn_d  = op;
                  state_d = CLEAR;
               end
            end
         end
         CLEAR: state_d = INIT;
         INIT:  state_d = LOAD;
         LOAD: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               dm_load  = 1'b1;
               dm_index = head_beat.index;
               dm_data  = head_beat.data;
               if (head_beat.last) begin
                  cnt_d   = 8'(RUN_CYCLES);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            dm_run = 1'b1;
            cnt_d  = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               res_data_d = dm_out;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         insn_q     <= 2'd0;
         res_data_q <= 12'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         insn_q     <= insn_d;
         res_data_q <= res_data_d;
         err_q      <= err_d;
      end
   end

   assign dm_rst_n  = rst_int_n && (state_q != CLEAR);
   assign dm_insn   = insn_q;
   assign res_valid = (state_q == DONE);
   assign res_data  = res_data_q;
   assign busy      = (state_q != IDLE);
   assign err       = err_q;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Self-checking bench: directed scenarios plus randomized jobs, scored
// against a transaction-level model of accepted beats and job results.
module tb_dmadd_sequencer;

   localparam int RUN_CYCLES = 16;
   localparam int DEPTH      = 4;

   typedef struct {
      logic [3:0] index;
      logic [3:0] data;
      logic       last;
   } mbeat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [3:0]  s_index = 4'd0;
   logic [3:0]  s_data = 4'd0;
   logic        s_last = 1'b0;
   logic        dm_rst_n;
   logic [1:0]  dm_insn;
   logic [3:0]  dm_index;
   logic [3:0]  dm_data;
   logic        dm_load;
   logic        dm_run;
   logic [11:0] dm_out = 12'd0;
   logic        res_valid;
   logic [11:0] res_data;
   logic        res_ready = 1'b0;
   logic        busy;
   logic        err;

   int total = 0;
   int bad   = 0;

   mbeat_t      acc_q[$];
   logic [11:0] exp_res;
   logic [1:0]  exp_insn = 2'd0;
   logic        exp_err = 1'b0;
   int cyc = 0, run_cnt = 0, clr_cnt = 0, clr_cyc = 0;
   int job_loads = 0, first_load_cyc = 0, last_load_cyc = 0;
   logic rv_prev = 1'b0;

   dmadd_sequencer #(.RUN_CYCLES(RUN_CYCLES), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .s_valid(s_valid), .s_ready(s_ready), .s_index(s_index), .s_data(s_data), .s_last(s_last),
      .dm_rst_n(dm_rst_n), .dm_insn(dm_insn), .dm_index(dm_index), .dm_data(dm_data),
      .dm_load(dm_load), .dm_run(dm_run), .dm_out(dm_out),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one beat from the posedge+1 phase and records it once the handshake is seen.
   task automatic send_beat(input logic [3:0] idx, input logic [3:0] dat, input logic lst, input int gap);
      mbeat_t b;
      repeat (gap) tick();
      b = '{index: idx, data: dat, last: lst};
      s_valid = 1'b1; s_index = idx; s_data = dat; s_last = lst;
      for (int w = 0; w < 200; w++) begin
         @(negedge clk);
         if (s_ready) begin
            acc_q.push_back(b);
            tick();
            s_valid = 1'b0;
            return;
         end
      end
      check("beat_timeout", 0, 1);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic start_job(input logic [1:0] jop);
      start = 1'b1; op = jop;
      if (jop != 2'd3) exp_insn = jop;
      tick();
      start = 1'b0; op = 2'd0;
   endtask

   task automatic wait_res();
      for (int w = 0; w < 500; w++) begin
         @(negedge clk);
         if (res_valid) begin
            #1;
            return;
         end
      end
      check("res_timeout", 0, 1);
   endtask

   task automatic finish_job(input int dly);
      repeat (dly) tick();
      tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      @(negedge clk);
      check("idle_after_ack", busy, 0);
      tick();
   endtask

   // Monitor: every engine load must match the next accepted beat, and each result
   // must follow exactly RUN_CYCLES run cycles after the last load of its job.
   initial begin
      mbeat_t b;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run_cnt = 0; clr_cnt = 0; job_loads = 0; rv_prev = 1'b0;
         end else begin
            cyc++;
            if (!dm_rst_n && busy) begin
               clr_cnt++; clr_cyc = cyc; job_loads = 0;
            end
            if (dm_load) begin
               if (job_loads == 0) first_load_cyc = cyc;
               job_loads++;
               if (acc_q.size() == 0) begin
                  check("load_underflow", 1, 0);
               end else begin
                  b = acc_q.pop_front();
                  check("load_index", dm_index, b.index);
                  check("load_data", dm_data, b.data);
                  if (b.last) begin
                     last_load_cyc = cyc; run_cnt = 0;
                  end
               end
            end
            if (dm_run) run_cnt++;
            if (res_valid && !rv_prev) begin
               check("run_cycles", run_cnt, RUN_CYCLES);
               check("latency", cyc - last_load_cyc, RUN_CYCLES + 1);
               check("res_data", res_data, exp_res);
               check("clear_pulses", clr_cnt, 1);
               check("dm_insn", dm_insn, exp_insn);
               clr_cnt = 0;
            end
            rv_prev = res_valid;
         end
      end
   end

   initial begin
      logic [11:0] held;
      logic        ok, ok2;
      int          nb, npre, seen;
      logic [1:0]  jop;

      // Reset state.
      #12;
      check("rst_s_ready", s_ready, 0);
      check("rst_dm_rst_n", dm_rst_n, 0);
      check("rst_outputs", {busy, res_valid, err, dm_load, dm_run, dm_insn}, 0);
      check("rst_res_data", res_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      check("post_rst_ready", s_ready, 1);
      check("post_rst_dm_rst_n", dm_rst_n, 1);

      // MADD: two beats prefilled, then start.
      dm_out = 12'hA5C; exp_res = 12'hA5C;
      send_beat(4'd3, 4'd5, 1'b0, 0);
      send_beat(4'd7, 4'd2, 1'b1, 0);
      start_job(2'd2);
      wait_res();
      check("madd_init_gap", first_load_cyc - clr_cyc, 2);
      check("madd_loads", job_loads, 2);
      finish_job(0);

      // Stall: first beat in, last beat held back.
      dm_out = 12'h3C1; exp_res = 12'h3C1;
      start_job(2'd0);
      send_beat(4'd1, 4'd1, 1'b0, 0);
      repeat (2) tick();
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (dm_load || dm_run || !busy) ok = 1'b0;
      end
      check("stall_hold", ok, 1);
      tick();
      send_beat(4'd4, 4'd9, 1'b1, 0);
      wait_res();
      check("stall_loads", job_loads, 2);
      finish_job(1);

      // Backpressure: four beats fill the FIFO while idle.
      dm_out = 12'h777; exp_res = 12'h777;
      for (int i = 0; i < 4; i++) send_beat(4'(i + 8), 4'(15 - i), 1'b0, 0);
      @(negedge clk);
      check("bp_not_ready", s_ready, 0);
      tick();
      start_job(2'd1);
      send_beat(4'd12, 4'd6, 1'b0, 0);
      send_beat(4'd13, 4'd0, 1'b1, 0);
      wait_res();
      check("bp_loads", job_loads, 6);
      check("bp_model_empty", acc_q.size(), 0);
      finish_job(0);

      // Illegal opcode.
      start_job(2'd3);
      exp_err = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (!dm_rst_n || busy) ok = 1'b0;
      end
      check("ill_err", err, 1);
      check("ill_quiet", ok, 1);
      tick();

      // Held result: result stays put while res_ready is low, start ignored.
      dm_out = 12'h9E2; exp_res = 12'h9E2;
      send_beat(4'd2, 4'd2, 1'b1, 0);
      start_job(2'd2);
      wait_res();
      held = res_data;
      ok = 1'b1; ok2 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         dm_out = 12'($urandom);
         start = (i == 3); op = 2'd0;
         @(negedge clk);
         if (res_data !== held) ok = 1'b0;
         if (!res_valid) ok2 = 1'b0;
      end
      check("held_data", ok, 1);
      check("held_valid", ok2, 1);
      check("sticky_err", err, 1);
      tick();
      start = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      @(negedge clk);
      check("held_idle", busy, 0);
      repeat (2) @(negedge clk);
      check("held_start_ignored", {busy, dm_insn}, {1'b0, 2'd2});
      tick();

      // Reset in the eighth run cycle, with leftover beats for a next job queued.
      dm_out = 12'h111; exp_res = 12'h111;
      send_beat(4'd5, 4'd5, 1'b1, 0);
      send_beat(4'd6, 4'd6, 1'b0, 0);
      send_beat(4'd7, 4'd7, 1'b0, 0);
      start_job(2'd0);
      seen = 0;
      for (int w = 0; w < 100 && seen < 8; w++) begin
         @(negedge clk);
         if (dm_run) seen++;
      end
      check("mid_run_reached", seen, 8);
      rst_n = 1'b0;
      #1;
      check("mid_rst_run", dm_run, 0);
      check("mid_rst_state", {busy, res_valid, s_ready, err}, 0);
      acc_q.delete();
      exp_err = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (res_valid) ok = 1'b0;
      end
      check("mid_rst_no_result", ok, 1);
      check("mid_rst_err_clear", err, 0);
      tick();
      dm_out = 12'h2B4; exp_res = 12'h2B4;
      start_job(2'd1);
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (dm_load) ok = 1'b0;
      end
      check("mid_rst_fifo_empty", ok, 1);
      tick();
      send_beat(4'd11, 4'd3, 1'b1, 0);
      wait_res();
      check("mid_rst_loads", job_loads, 1);
      finish_job(0);

      // Randomized jobs.
      for (int j = 0; j < 20; j++) begin
         jop = 2'($urandom_range(0, 3));
         if (jop == 2'd3) begin
            start_job(jop);
            exp_err = 1'b1;
            @(negedge clk);
            check("rnd_illegal", {err, busy}, {1'b1, 1'b0});
            tick();
         end else begin
            dm_out  = 12'($urandom);
            exp_res = dm_out;
            nb      = $urandom_range(1, 6);
            npre    = $urandom_range(0, (nb < DEPTH) ? nb : DEPTH);
            for (int i = 0; i < npre; i++)
               send_beat(4'($urandom), 4'($urandom), i == nb - 1, $urandom_range(0, 2));
            start_job(jop);
            for (int i = npre; i < nb; i++)
               send_beat(4'($urandom), 4'($urandom), i == nb - 1, $urandom_range(0, 3));
            wait_res();
            check("rnd_loads", job_loads, nb);
            check("rnd_err", err, exp_err);
            finish_job($urandom_range(0, 4));
         end
      end
      check("final_model_empty", acc_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
